// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register plus data bit counter for one UART frame.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic             cnt_clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ser_data_o,
    output logic             ser_done_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
        end else if (shift_en_i) begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end
        // The counter parks at WIDTH-1 until the next frame clears it.
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (shift_en_i && !ser_done_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_data_o = shift_q[0];
    assign ser_done_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data LSB-first, optional parity, stop.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Data_Valid,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             PAR_EN,
    input  logic             parity,
    output logic             TX_OUT,
    output logic             Busy
);

    state_e state_q, state_d;
    logic   tx_q, tx_d;
    logic   busy_q, busy_d;
    logic   par_en_q, par_en_d;
    logic   load, shift_en, cnt_clr;
    logic   ser_data, ser_done;

    uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (load),
        .shift_en_i (shift_en),
        .cnt_clr_i  (cnt_clr),
        .data_i     (P_DATA),
        .ser_data_o (ser_data),
        .ser_done_o (ser_done)
    );

    // TX_OUT is registered, so it is loaded with the level of the next state.
    always_comb begin
        state_d  = state_q;
        par_en_d = par_en_q;
        tx_d     = IDLE_LEVEL;
        load     = 1'b0;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    load     = 1'b1;
                    par_en_d = PAR_EN;
                    state_d  = START;
                    tx_d     = START_BIT;
                end
            end
            START: begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                state_d  = DATA;
                tx_d     = ser_data;
            end
            DATA: begin
                if (!ser_done) begin
                    shift_en = 1'b1;
                    tx_d     = ser_data;
                end else if (par_en_q) begin
                    state_d = PARITY;
                    tx_d    = parity;
                end else begin
                    state_d = STOP;
                    tx_d    = STOP_BIT;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
            end
            STOP: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            par_en_q <= par_en_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
